lsq_mem_scheduler: RTL and testbench

- In-order load/store request scheduler between the pipeline's memory stage and the single-ported DCache4KB.
- Buffers up to DEPTH requests in a circular FIFO and issues them one at a time to the cache port.
- Holds each access for a fixed MEM_LATENCY cycles, then returns data tagged with the ld/st queue id.
- Raises stall_out while the FIFO cannot accept a request.

---
 rtl/lsq_mem_scheduler.sv | 137 +++++++++++++
 tb/tb_lsq_mem_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsq_mem_scheduler.sv
// In-order load/store scheduler: DEPTH-entry circular FIFO feeding a single-ported cache.
// Latency: accept at T -> ready_out at T+MEM_LATENCY+2 (FIFO empty and idle).
// Backpressure: stall_out while the FIFO is full; requests presented while stalled are ignored.
// Optional LSQ_STORE_ACK_EN: stores also produce a ready_out pulse carrying the store data.
module lsq_mem_scheduler #(
    parameter int DEPTH       = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_in,
    input  logic        rw_in,
    input  logic [3:0]  id_in,
    input  logic        valid_in,
    output logic [31:0] data_out,
    output logic [3:0]  id_out,
    output logic        ready_out,
    output logic        stall_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_data_out,
    output logic        mem_rw_out,
    input  logic [31:0] mem_rdata_in
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

`ifdef LSQ_STORE_ACK_EN
    localparam bit STORE_ACK = 1'b1;
`else
    localparam bit STORE_ACK = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic [3:0]  id;
    } req_t;

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    req_t          fifo_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    state_t        state_q, state_nxt;
    logic [LW-1:0] lat_q;
    logic          issue_rw_q;
    logic [3:0]    issue_id_q;
    logic          push, pop, latch_issue, capture;

    // A same-cycle pop never frees a slot for an enqueue while full.
    assign stall_out = (count_q == CW'(DEPTH));
    assign push      = valid_in && !stall_out;
    assign capture   = (state_q == ACCESS) && (lat_q == '0) && (!issue_rw_q || STORE_ACK);

    always_comb begin
        state_nxt   = state_q;
        pop         = 1'b0;
        latch_issue = 1'b0;
        ready_out   = 1'b0;
        mem_rw_out  = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    latch_issue = 1'b1;
                    state_nxt   = ACCESS;
                end
            end
            ACCESS: begin
                if (lat_q == '0) begin
                    mem_rw_out = issue_rw_q;
                    // Unacknowledged stores retire straight from the final access cycle.
                    if (issue_rw_q && !STORE_ACK) begin
                        pop       = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = RESPOND;
                    end
                end
            end
            RESPOND: begin
                ready_out = 1'b1;
                pop       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[tail_q] <= '{addr: addr_in, data: data_in, rw: rw_in, id: id_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            lat_q        <= '0;
            issue_rw_q   <= 1'b0;
            issue_id_q   <= '0;
            data_out     <= '0;
            id_out       <= '0;
            mem_addr_out <= '0;
            mem_data_out <= '0;
        end else begin
            state_q <= state_nxt;
            if (push) begin
                tail_q <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
            if (latch_issue) begin
                mem_addr_out <= fifo_q[head_q].addr;
                mem_data_out <= fifo_q[head_q].data;
                issue_rw_q   <= fifo_q[head_q].rw;
                issue_id_q   <= fifo_q[head_q].id;
                lat_q        <= LW'(MEM_LATENCY - 1);
            end else if (state_q == ACCESS && lat_q != '0) begin
                lat_q <= lat_q - 1'b1;
            end
            if (capture) begin
                data_out <= issue_rw_q ? mem_data_out : mem_rdata_in;
                id_out   <= issue_id_q;
            end
        end
    end

endmodule

// File: tb/tb_lsq_mem_scheduler.sv
// Bench for lsq_mem_scheduler: directed scenarios plus randomized traffic against a
// transaction-level model that schedules each accepted request in time.
module tb_lsq_mem_scheduler;

    localparam int DEPTH = 8;
    localparam int ML    = 2;
`ifdef LSQ_STORE_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr_in, data_in, data_out, mem_addr_out, mem_data_out, mem_rdata_in;
    logic        rw_in, valid_in, ready_out, stall_out, mem_rw_out;
    logic [3:0]  id_in, id_out;

    lsq_mem_scheduler #(.DEPTH(DEPTH), .MEM_LATENCY(ML)) dut (
        .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .data_in(data_in), .rw_in(rw_in),
        .id_in(id_in), .valid_in(valid_in), .data_out(data_out), .id_out(id_out),
        .ready_out(ready_out), .stall_out(stall_out), .mem_addr_out(mem_addr_out),
        .mem_data_out(mem_data_out), .mem_rw_out(mem_rw_out), .mem_rdata_in(mem_rdata_in)
    );

    always #5 clk = ~clk;

    // Cache environment: combinational read, write on the clock edge.
    logic [31:0] cache [64];
    assign mem_rdata_in = cache[mem_addr_out[7:2]];
    always @(posedge clk) if (mem_rw_out) cache[mem_addr_out[7:2]] <= mem_data_out;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        logic        rw;
        logic [3:0]  id;
        int          resp;
        int          wr;
        int          pop;
    } rec_t;

    rec_t        recs[$];
    logic [31:0] ref_mem [64];
    logic [31:0] last_data;
    logic [3:0]  last_id;
    logic [3:0]  rdy_ids[$];
    logic [31:0] rdy_data;
    logic [3:0]  rdy_id;
    int          free_cyc, cyc, checks, errors, n_ready, n_wr, rdy_cyc, t0, t1, base;
    bit          saw_stall, acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: inputs are already applied; check at the falling edge, then
    // let the model absorb the request the DUT should accept at the rising edge.
    task automatic cycle(output bit accepted);
        int   cnt, i;
        bit   e_stall, e_rdy, e_wr;
        rec_t wrec, r;
        accepted = 1'b0;
        @(negedge clk);
        if (ready_out) begin
            n_ready++; rdy_cyc = cyc; rdy_data = data_out; rdy_id = id_out;
            rdy_ids.push_back(id_out);
        end
        if (mem_rw_out) n_wr++;
        if (stall_out) saw_stall = 1'b1;
        if (rst_n) begin
            cnt = 0; e_rdy = 1'b0; e_wr = 1'b0;
            foreach (recs[k]) begin
                if (recs[k].pop >= cyc) cnt++;
                if (recs[k].resp == cyc) begin
                    e_rdy = 1'b1;
                    last_data = recs[k].rw ? recs[k].data : recs[k].exp;
                    last_id = recs[k].id;
                end
                if (recs[k].rw && recs[k].wr == cyc) begin e_wr = 1'b1; wrec = recs[k]; end
            end
            e_stall = (cnt == DEPTH);
            chk("stall_out", 32'(stall_out), 32'(e_stall));
            chk("ready_out", 32'(ready_out), 32'(e_rdy));
            chk("data_out", data_out, last_data);
            chk("id_out", 32'(id_out), 32'(last_id));
            chk("mem_rw_out", 32'(mem_rw_out), 32'(e_wr));
            if (e_wr) begin
                chk("mem_addr_out", mem_addr_out, wrec.addr);
                chk("mem_data_out", mem_data_out, wrec.data);
            end
            if (valid_in && !e_stall) begin
                accepted = 1'b1;
                i = (cyc + 1 > free_cyc) ? cyc + 1 : free_cyc;
                r.addr = addr_in; r.data = data_in; r.rw = rw_in; r.id = id_in;
                r.wr = i + ML; r.exp = '0;
                if (rw_in) ref_mem[addr_in[7:2]] = data_in;
                else       r.exp = ref_mem[addr_in[7:2]];
                if (rw_in && !ACK) begin
                    r.resp = -1; r.pop = i + ML; free_cyc = i + ML + 1;
                end else begin
                    r.resp = i + ML + 1; r.pop = r.resp; free_cyc = r.resp + 1;
                end
                recs.push_back(r);
            end
            while (recs.size() > 0 && recs[0].pop < cyc) void'(recs.pop_front());
        end else begin
            recs.delete(); free_cyc = cyc + 1; last_data = '0; last_id = '0;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic run(input int n);
        bit a;
        valid_in = 1'b0;
        for (int k = 0; k < n; k++) cycle(a);
    endtask

    // Present a request and hold it until accepted; t_acc is the accepting cycle.
    task automatic send(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] id, output int t_acc);
        bit a;
        a = 1'b0; t_acc = -1;
        valid_in = 1'b1; rw_in = rw; addr_in = addr; data_in = data; id_in = id;
        for (int w = 0; w < 60 && !a; w++) begin
            cycle(a);
            if (a) t_acc = cyc - 1;
        end
        chk("accept_timeout", 32'(a), 32'd1);
        valid_in = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; free_cyc = 0; n_ready = 0; n_wr = 0;
        rdy_cyc = -1; saw_stall = 1'b0; last_data = '0; last_id = '0;
        rst_n = 1'b0; valid_in = 1'b0; rw_in = 1'b0; addr_in = '0; data_in = '0; id_in = '0;
        for (int k = 0; k < 64; k++) begin cache[k] = $urandom(); ref_mem[k] = cache[k]; end
        cache[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
        #1;
        run(2);
        rst_n = 1'b1;
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_id_out", 32'(id_out), 32'h0);
        chk("rst_ready_out", 32'(ready_out), 32'h0);
        chk("rst_stall_out", 32'(stall_out), 32'h0);
        chk("rst_mem_addr", mem_addr_out, 32'h0);
        chk("rst_mem_data", mem_data_out, 32'h0);
        chk("rst_mem_rw", 32'(mem_rw_out), 32'h0);
        run(20);
        chk("idle_no_ready", 32'(n_ready), 32'd0);

        // Single load of word 5.
        base = n_ready;
        send(1'b0, 32'h14, 32'h0, 4'd3, t0);
        run(8);
        chk("load_latency", 32'(rdy_cyc - t0), 32'd4);
        chk("load_data", rdy_data, 32'hDEADBEEF);
        chk("load_id", 32'(rdy_id), 32'd3);
        chk("load_count", 32'(n_ready - base), 32'd1);

        // Store then load of the same address.
        base = rdy_ids.size(); n_wr = 0;
        send(1'b1, 32'h40, 32'h12345678, 4'd1, t0);
        send(1'b0, 32'h40, 32'h0, 4'd2, t1);
        run(12);
        chk("st_ld_one_write", 32'(n_wr), 32'd1);
        chk("st_ld_data", rdy_data, 32'h12345678);
        chk("st_ld_id", 32'(rdy_id), 32'd2);
        chk("st_ld_latency", 32'(rdy_cyc - t1), ACK ? 32'd7 : 32'd6);
        chk("st_ld_resp_count", 32'(rdy_ids.size() - base), ACK ? 32'd2 : 32'd1);
        if (ACK && rdy_ids.size() - base == 2) chk("st_ack_id", 32'(rdy_ids[base]), 32'd1);

        // Back-to-back loads past full, with hold-and-retry.
        base = rdy_ids.size(); saw_stall = 1'b0;
        for (int k = 0; k < 12; k++) send(1'b0, 32'h100 + 32'(k * 4), 32'h0, 4'(k), t0);
        run(60);
        chk("fill_saw_stall", 32'(saw_stall), 32'd1);
        chk("fill_resp_count", 32'(rdy_ids.size() - base), 32'd12);
        for (int k = 0; k < 12 && base + k < rdy_ids.size(); k++)
            chk("fill_order", 32'(rdy_ids[base + k]), 32'(k));

        // Reset while the first of three loads is in its access phase.
        send(1'b0, 32'h20, 32'h0, 4'd4, t0);
        send(1'b0, 32'h24, 32'h0, 4'd5, t1);
        send(1'b0, 32'h28, 32'h0, 4'd6, t1);
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        base = n_ready;
        run(10);
        chk("mid_rst_no_ready", 32'(n_ready - base), 32'd0);
        chk("mid_rst_stall", 32'(stall_out), 32'd0);
        send(1'b0, 32'h14, 32'h0, 4'd9, t0);
        run(8);
        chk("post_rst_latency", 32'(rdy_cyc - t0), 32'd4);
        chk("post_rst_data", rdy_data, 32'hDEADBEEF);
        chk("post_rst_id", 32'(rdy_id), 32'd9);

        // Store id 7 then load id 8.
        base = rdy_ids.size();
        send(1'b1, 32'h80, 32'hCAFEF00D, 4'd7, t0);
        send(1'b0, 32'h80, 32'h0, 4'd8, t1);
        run(12);
        t0 = 0;
        for (int k = base; k < rdy_ids.size(); k++) if (rdy_ids[k] == 4'd7) t0++;
        chk("store7_acks", 32'(t0), ACK ? 32'd1 : 32'd0);
        chk("load8_latency", 32'(rdy_cyc - t1), ACK ? 32'd7 : 32'd6);
        chk("load8_data", rdy_data, 32'hCAFEF00D);

        // Randomized traffic over a small set of cache words.
        for (int k = 0; k < 300; k++) begin
            send(1'($urandom_range(0, 1)),
                 ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 7) << 2),
                 $urandom(), 4'($urandom_range(0, 15)), t0);
            if ($urandom_range(0, 3) == 0) run($urandom_range(1, 6));
        end
        run(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
